uart_rx_mmio: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the SoC's transmit UART.
- Oversamples the pin at the system clock, recovers bytes and buffers them for the CPU.
- The SoC IO decoder pops bytes and reads status flags through a valid/ready handshake.
- Sits beside the TX UART, on the same clk and baud settings.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_mmio_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 100 ++++++++++
 rtl/uart_rx_mmio.sv | 118 +++++++++++
 tb/tb_uart_rx_mmio.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, data width and
// baud-timing helpers used by the receiver and its testbench-facing top.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   // System clocks per serial bit (integer division, truncating).
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Clocks from the start-bit edge to the middle of the start bit.
   function automatic int half_bit(input int clk_hz, input int baud);
      return clks_per_bit(clk_hz, baud) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Consumer-side bus of the UART receiver: byte pop handshake plus status.
// master = receiver (produces bytes), slave = IO decoder (pops them).
interface uart_rx_mmio_if;
   import uart_pkg::*;

   logic [UART_DATA_W-1:0] o_data;
   logic                   o_valid;
   logic                   i_ready;
   logic                   o_frame_err;
   logic                   o_overrun;
   logic                   i_clr_err;
   logic                   o_busy;

   modport master (
      output o_data, o_valid, o_frame_err, o_overrun, o_busy,
      input  i_ready, i_clr_err
   );

   modport slave (
      input  o_data, o_valid, o_frame_err, o_overrun, o_busy,
      output i_ready, i_clr_err
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer with sticky overrun flag.
// UART_RX_FIFO_EN defined  : DEPTH-entry circular FIFO, first-word fall-through.
// UART_RX_FIFO_EN undefined: single holding register plus a full flag.
// A push into a full buffer is accepted only when a pop happens the same cycle;
// otherwise the byte is dropped and overrun is set (set wins over clr_err).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [UART_DATA_W-1:0] din,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] dout,
   output logic                   valid,
   output logic                   full,
   input  logic                   clr_err,
   output logic                   overrun
);

   // Reject unusable depths at elaboration, in either build.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic pop_ok;
   logic push_ok;

   assign pop_ok  = pop & valid;
   assign push_ok = push & (~full | pop_ok);

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(DEPTH);

   logic [UART_DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]          rd_ptr;
   logic [AW-1:0]          wr_ptr;
   logic [AW:0]            count;

   assign valid = (count != '0);
   assign full  = (count == (AW+1)'(DEPTH));
   // NOTE: the storage array has no reset; dout is masked while empty so the
   // visible output still reads 0 out of reset without resetting every entry.
   assign dout  = valid ? mem[rd_ptr] : '0;

   // Storage write; pointers wrap naturally at 2**AW.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
`else
   logic [UART_DATA_W-1:0] hold;

   assign valid = full;
   assign dout  = hold;

   // Single-entry buffer: a push in the same cycle as a pop refills it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold <= '0;
         full <= 1'b0;
      end else begin
         if (pop_ok) full <= 1'b0;
         if (push_ok) begin
            hold <= din;
            full <= 1'b1;
         end
      end
   end
`endif

   // Sticky overrun: set when a byte is dropped, cleared by clr_err.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else begin
         if (clr_err) overrun <= 1'b0;
         if (push & full & ~pop_ok) overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with CPU-facing pop handshake.
// Optional macro UART_RX_FIFO_EN selects a FIFO_DEPTH-entry buffer instead of
// a single holding register.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_uart_rx,
   uart_rx_mmio_if.master    bus
);

   localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam int         HALF_BIT     = half_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam logic [15:0] CNT_BIT_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] CNT_HALF_END = 16'(HALF_BIT - 1);

   logic                   rx_meta;
   logic                   rx_s;
   state_e                 state;
   logic [15:0]            cnt;
   logic [2:0]             idx;
   logic [UART_DATA_W-1:0] shift;
   logic                   frame_err;
   logic                   push;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_s    <= rx_meta;
      end
   end

   // A good stop bit delivers the byte in the same cycle it is sampled.
   assign push = (state == STOP) && (cnt == CNT_BIT_END) && rx_s;

   // Receive FSM: start validation at mid-bit, 8 data samples, stop check.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         frame_err <= 1'b0;
      end else begin
         // NOTE: with non-blocking assignments the last one in the block wins,
         // so a framing error set further down overrides this clear.
         if (bus.i_clr_err) frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_HALF_END) begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     cnt   <= '0;
                     idx   <= '0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == CNT_BIT_END) begin
                  shift <= {rx_s, shift[UART_DATA_W-1:1]};
                  cnt   <= '0;
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (cnt == CNT_BIT_END) begin
                  if (!rx_s) frame_err <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_busy      = (state != IDLE);
   assign bus.o_frame_err = frame_err;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .din     (shift),
      .pop     (bus.i_ready),
      .dout    (bus.o_data),
      .valid   (bus.o_valid),
      .full    (),
      .clr_err (bus.i_clr_err),
      .overrun (bus.o_overrun)
   );

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: serial frames are driven bit by bit and
// received bytes and flags are compared against a queue-based buffer model.
module tb_uart_rx_mmio;

   localparam int CPB  = 50_000_000 / 115_200;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_FIFO_EN
   localparam int DEPTH = 8;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_line = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_q[$];
   logic [7:0] popped[$];
   logic       exp_ferr = 1'b0;
   logic       exp_ovr  = 1'b0;

   uart_rx_mmio_if bus ();

   uart_rx_mmio #(
      .CLK_FREQ_HZ (50_000_000),
      .BAUD_RATE   (115_200),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_uart_rx (rx_line),
      .bus       (bus)
   );

   always #10 clk = ~clk;

   // Every accepted pop, recorded away from the clock edge.
   always @(negedge clk) begin
      if (!reset && bus.o_valid && bus.i_ready) popped.push_back(bus.o_data);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val);
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(CPB);
      end
      rx_line = stop_val;
      tick(CPB);
      rx_line = 1'b1;
   endtask

   // Buffer model: good bytes enter while there is room, else overrun.
   task automatic model_frame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok)                   exp_ferr = 1'b1;
      else if (model_q.size() < DEPTH) model_q.push_back(b);
      else                            exp_ovr = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.o_busy && n < 2000) begin
         tick(1);
         n++;
      end
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: busy still %b after %0d cycles", name, bus.o_busy, n);
      end
   endtask

   task automatic check_flags(input string name);
      checks++;
      if (bus.o_frame_err !== exp_ferr) begin
         errors++;
         $display("FAIL %s frame_err: got %b need %b", name, bus.o_frame_err, exp_ferr);
      end
      checks++;
      if (bus.o_overrun !== exp_ovr) begin
         errors++;
         $display("FAIL %s overrun: got %b need %b", name, bus.o_overrun, exp_ovr);
      end
   endtask

   task automatic clear_flags();
      bus.i_clr_err = 1'b1;
      tick(1);
      bus.i_clr_err = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
   endtask

   // Pop every byte the model holds, in order, then expect empty.
   task automatic drain_check(input string name);
      logic [7:0] exp;
      while (model_q.size() > 0) begin
         exp = model_q.pop_front();
         checks++;
         if (bus.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b need 1 (expecting %h)", name, bus.o_valid, exp);
         end else if (bus.o_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h need %h", name, bus.o_data, exp);
         end
         bus.i_ready = 1'b1;
         tick(1);
         bus.i_ready = 1'b0;
      end
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s empty: valid got %b need 0", name, bus.o_valid);
      end
   endtask

   task automatic test_reset();
      tick(5);
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_in: busy=%b valid=%b need 0 0", bus.o_busy, bus.o_valid);
      end
      reset = 1'b0;
      tick(3);
      checks++;
      if (bus.o_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h need 00", bus.o_data);
      end
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: valid=%b busy=%b need 0 0", bus.o_valid, bus.o_busy);
      end
      check_flags("reset");
   endtask

   task automatic test_single_byte();
      int lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!bus.o_valid && lat < 6000) begin
               tick(1);
               lat++;
            end
         end
      join
      model_frame(8'hA5, 1'b1);
      checks++;
      if (lat < 4123 || lat > 4126) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles need 4123..4126", lat);
      end
      check_flags("single");
      drain_check("single");
   endtask

   task automatic test_glitch();
      int busy_cnt = 0;
      fork
         begin
            rx_line = 1'b0;
            tick(100);
            rx_line = 1'b1;
         end
         begin
            for (int i = 0; i < 400; i++) begin
               tick(1);
               if (bus.o_busy) busy_cnt++;
            end
         end
      join
      checks++;
      if (busy_cnt < HALF - 1 || busy_cnt > HALF + 1) begin
         errors++;
         $display("FAIL glitch_busy: busy for %0d cycles need about %0d", busy_cnt, HALF);
      end
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL glitch_end: busy=%b valid=%b need 0 0", bus.o_busy, bus.o_valid);
      end
      check_flags("glitch");
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0);
      model_frame(8'h3C, 1'b0);
      wait_idle("frame_err");
      check_flags("frame_err");
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_valid: got %b need 0", bus.o_valid);
      end
      clear_flags();
      check_flags("frame_err_clr");
   endtask

   task automatic test_overrun();
      for (int i = 0; i <= DEPTH; i++) begin
         send_frame(8'(i), 1'b1);
         model_frame(8'(i), 1'b1);
      end
      wait_idle("overrun");
      check_flags("overrun");
      drain_check("overrun");
      clear_flags();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[2];
      exp[0] = 8'h55;
      exp[1] = 8'hAA;
      popped.delete();
      bus.i_ready = 1'b1;
      send_frame(exp[0], 1'b1);
      send_frame(exp[1], 1'b1);
      tick(10);
      bus.i_ready = 1'b0;
      checks++;
      if (popped.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d bytes need 2", popped.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (popped[i] !== exp[i]) begin
               errors++;
               $display("FAIL b2b_data%0d: got %h need %h", i, popped[i], exp[i]);
            end
         end
      end
      check_flags("b2b");
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       ok;
      for (int i = 0; i < 3; i++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send_frame(b, ok);
         model_frame(b, ok);
         if (!ok) tick(2 * CPB);
      end
      wait_idle("random");
      check_flags("random");
      drain_check("random");
      clear_flags();
   endtask

   task automatic test_reset_midframe();
      logic [7:0] partial = 8'h5A;
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_line = partial[i];
         tick(CPB);
      end
      rx_line = partial[4];
      tick(CPB / 2);
      reset = 1'b1;
      rx_line = 1'b1;
      tick(3);
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: busy=%b valid=%b need 0 0", bus.o_busy, bus.o_valid);
      end
      reset = 1'b0;
      tick(20);
      send_frame(8'h81, 1'b1);
      model_frame(8'h81, 1'b1);
      wait_idle("rst_mid");
      check_flags("rst_mid");
      drain_check("rst_mid");
   endtask

   initial begin
      bus.i_ready   = 1'b0;
      bus.i_clr_err = 1'b0;
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_random();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
